// File: rtl/mac_spike_scheduler.sv
// mac_spike_scheduler
//   Timestep controller and spike-address arbiter for the MAC array.
//   Requesters offer source-neuron addresses; a round-robin arbiter moves at
//   most one per cycle into an address FIFO. The FIFO is popped one entry per
//   cycle onto a registered broadcast bus shared by every MAC. At timestep
//   end the FIFO is drained, the MAC clear window is driven and the block
//   waits for every MAC to report done before pulsing timestep_done.
//
// Handshake: a requester transfers on a cycle where req_valid[i] & req_ready[i]
//   are both high at the rising edge. req_ready is one-hot, combinational,
//   and only asserted in COLLECT when the FIFO is not full. A requester must
//   hold valid and address stable until it sees ready.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   timestep_start    begin a timestep (IDLE only)
//   timestep_end      stop accepting spikes (COLLECT only)
//   req_valid/addr    per-requester address offer, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready         one-hot grant
//   source_address/source_valid  registered broadcast to the MACs
//   clear             MAC end-of-timestep strobe, CLEAR_CYCLES long
//   mac_done          per-MAC done flags
//   timestep_done     one-cycle completion pulse
//   busy              high whenever the FSM is not IDLE
//   dbg_state_o       current FSM state for observation
module mac_spike_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int NUM_MAC      = 10,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      timestep_start,
  input  logic                      timestep_end,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         source_address,
  output logic                      source_valid,
  output logic                      clear,
  input  logic [NUM_MAC-1:0]        mac_done,
  output logic                      timestep_done,
  output logic                      busy,
  output logic [2:0]                dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_DRAIN     = 3'd2,
    S_CLEAR     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       clr_cnt_q;
  logic                source_valid_q;
  logic [ADDR_W-1:0]   source_address_q;
  logic                clear_q;
  logic                timestep_done_q;
  logic                busy_q;

  // FIFO pointers carry one extra wrap bit: equal pointers mean empty,
  // equal low bits with differing MSB mean full.
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0]   mem_q [FIFO_DEPTH];
  logic                fifo_empty, fifo_full;

  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       grant_idx;
  logic                grant_any;
  logic [PW:0]         cand;
  logic                push, pop;
  logic [ADDR_W-1:0]   push_addr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Search from the priority pointer upward, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!grant_any && req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_COLLECT && grant_any && !fifo_full) req_ready[grant_idx] = 1'b1;
  end

  assign push      = |(req_valid & req_ready);
  assign push_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign pop       = (state_q == S_COLLECT || state_q == S_DRAIN) && !fifo_empty;
  assign rr_ptr_d  = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);

  // FIFO and arbiter pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
        rr_ptr_q <= rr_ptr_d;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_addr;
  end

  // Timestep FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= S_IDLE;
      clr_cnt_q        <= '0;
      source_valid_q   <= 1'b0;
      source_address_q <= '0;
      clear_q          <= 1'b0;
      timestep_done_q  <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      source_valid_q  <= pop;
      if (pop) source_address_q <= mem_q[rd_ptr_q[AW-1:0]];
      clear_q         <= 1'b0;
      timestep_done_q <= 1'b0;
      busy_q          <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          busy_q <= timestep_start;
          if (timestep_start) state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (timestep_end) state_q <= S_DRAIN;
        end
        // Leave only once the last pop has already been issued, so the
        // final source_valid never overlaps clear.
        S_DRAIN: begin
          if (fifo_empty) begin
            state_q   <= S_CLEAR;
            clear_q   <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == CW'(CLEAR_CYCLES-1)) begin
            state_q <= S_WAIT_DONE;
          end else begin
            clr_cnt_q <= clr_cnt_q + CW'(1);
            clear_q   <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (&mac_done) begin
            state_q         <= S_DONE;
            timestep_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign source_valid   = source_valid_q;
  assign source_address = source_address_q;
  assign clear          = clear_q;
  assign timestep_done  = timestep_done_q;
  assign busy           = busy_q;
  assign dbg_state_o    = state_q;

endmodule
